countdown_timer: RTL and testbench

//  Main MM:SS BCD countdown datapath plus its alarm sequencer for the egg timer.

---
 rtl/countdown_timer.sv | 157 +++++++++++++++
 tb/tb_countdown_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown datapath with an optional alarm beep sequencer.
// Define COUNTDOWN_ALARM_EN to build the alarm FSM; otherwise alarm is tied low.
module countdown_timer #(
    parameter int unsigned BEEP_COUNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       beat_pulse,
    input  logic       load,
    input  logic       enable,
    input  logic       alarm_ack,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_sec_tens,
    input  logic [3:0] load_sec_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       done_pulse,
    output logic       alarm
);

    localparam int unsigned DIGIT_W = 4;

    logic [DIGIT_W-1:0] min_tens_d, min_ones_d, sec_tens_d, sec_ones_d;
    logic               decrement;
    logic               at_one_sec;
    logic               done_pulse_d;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                       input logic [DIGIT_W-1:0] max_d);
        return (d > max_d) ? max_d : d;
    endfunction

    assign timer_done = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd0);
    assign at_one_sec = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd1);
    assign decrement  = tick_1hz & enable & ~load & ~timer_done;

    // Load with per-digit clamp, else borrow-chain decrement, else hold.
    always_comb begin
        min_tens_d   = min_tens;
        min_ones_d   = min_ones;
        sec_tens_d   = sec_tens;
        sec_ones_d   = sec_ones;
        done_pulse_d = decrement & at_one_sec;
        if (load) begin
            min_tens_d = clamp_digit(load_min_tens, 4'd9);
            min_ones_d = clamp_digit(load_min_ones, 4'd9);
            sec_tens_d = clamp_digit(load_sec_tens, 4'd5);
            sec_ones_d = clamp_digit(load_sec_ones, 4'd9);
        end else if (decrement) begin
            if (sec_ones != 4'd0) begin
                sec_ones_d = sec_ones - 4'd1;
            end else begin
                sec_ones_d = 4'd9;
                if (sec_tens != 4'd0) begin
                    sec_tens_d = sec_tens - 4'd1;
                end else begin
                    sec_tens_d = 4'd5;
                    if (min_ones != 4'd0) begin
                        min_ones_d = min_ones - 4'd1;
                    end else begin
                        min_ones_d = 4'd9;
                        min_tens_d = min_tens - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            done_pulse <= 1'b0;
        end else begin
            min_tens   <= min_tens_d;
            min_ones   <= min_ones_d;
            sec_tens   <= sec_tens_d;
            sec_ones   <= sec_ones_d;
            done_pulse <= done_pulse_d;
        end
    end

`ifdef COUNTDOWN_ALARM_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_BEEP_ON  = 2'd1,
        S_BEEP_OFF = 2'd2
    } alarm_state_t;

    alarm_state_t       state_q, state_d;
    logic [DIGIT_W-1:0] beeps_left_q, beeps_left_d;
    logic               alarm_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            beeps_left_q <= 4'd0;
            alarm        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beeps_left_q <= beeps_left_d;
            alarm        <= alarm_d;
        end
    end

    // Ack or load silences from any state and wins over a coincident done_pulse.
    always_comb begin
        state_d      = state_q;
        beeps_left_d = beeps_left_q;
        if (alarm_ack || load) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (done_pulse) begin
                        state_d      = S_BEEP_ON;
                        beeps_left_d = DIGIT_W'(BEEP_COUNT);
                    end
                end
                S_BEEP_ON: begin
                    if (beat_pulse) state_d = S_BEEP_OFF;
                end
                S_BEEP_OFF: begin
                    if (beat_pulse) begin
                        if (beeps_left_q == 4'd1) begin
                            state_d = S_IDLE;
                        end else begin
                            beeps_left_d = beeps_left_q - 4'd1;
                            state_d      = S_BEEP_ON;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Registered alarm tracks the BEEP_ON state exactly.
    always_comb begin
        alarm_d = (state_d == S_BEEP_ON);
    end
`else
    logic unused_alarm_inputs;
    assign unused_alarm_inputs = ^{alarm_ack, beat_pulse, DIGIT_W'(BEEP_COUNT)};
    assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with a seconds-based reference model.
// Alarm expectations follow whether COUNTDOWN_ALARM_EN is defined.
module tb_countdown_timer;

    localparam int BEEPS = 3;
`ifdef COUNTDOWN_ALARM_EN
    localparam int ALARM_ON = 1;
`else
    localparam int ALARM_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0, beat_pulse = 1'b0, load = 1'b0;
    logic       enable = 1'b1, alarm_ack = 1'b0;
    logic [3:0] load_min_tens = 4'd0, load_min_ones = 4'd0;
    logic [3:0] load_sec_tens = 4'd0, load_sec_ones = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       timer_done, done_pulse, alarm;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.BEEP_COUNT(BEEPS)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .beat_pulse(beat_pulse),
        .load(load), .enable(enable), .alarm_ack(alarm_ack),
        .load_min_tens(load_min_tens), .load_min_ones(load_min_ones),
        .load_sec_tens(load_sec_tens), .load_sec_ones(load_sec_ones),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
        .timer_done(timer_done), .done_pulse(done_pulse), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: remaining time as plain seconds, alarm as a beat-phase index.
    int m_secs = 0;
    bit m_dp = 0;
    bit m_active = 0;
    int m_phase = 0;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_secs = 0; m_dp = 0; m_active = 0; m_phase = 0;
        end else begin
`ifdef COUNTDOWN_ALARM_EN
            if (alarm_ack || load) m_active = 0;
            else if (!m_active) begin
                if (m_dp) begin m_active = 1; m_phase = 0; end
            end else if (beat_pulse) begin
                m_phase++;
                if (m_phase == 2 * BEEPS) m_active = 0;
            end
`endif
            m_dp = 0;
            if (load) begin
                m_secs = clampi(int'(load_min_tens), 9) * 600 + clampi(int'(load_min_ones), 9) * 60
                       + clampi(int'(load_sec_tens), 5) * 10 + clampi(int'(load_sec_ones), 9);
            end else if (tick_1hz && enable && m_secs != 0) begin
                m_secs--;
                m_dp = (m_secs == 0);
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [18:0] exp_v, act_v;
        exp_v = {4'(m_secs / 600), 4'((m_secs / 60) % 10), 4'((m_secs % 60) / 10),
                 4'(m_secs % 10), m_secs == 0, m_dp, m_active && (m_phase % 2 == 0)};
        act_v = {min_tens, min_ones, sec_tens, sec_ones, timer_done, done_pulse, alarm};
        check("cycle_outputs", 32'(act_v), 32'(exp_v));
    end

    int rises = 0;
    int dp_count = 0;
    logic alarm_prev = 1'b0;
    always @(negedge clk) begin
        if (alarm && !alarm_prev) rises++;
        if (done_pulse) dp_count++;
        alarm_prev = alarm;
    end

    task automatic pulse(input logic t, input logic b, input logic l, input logic a);
        @(negedge clk);
        tick_1hz = t; beat_pulse = b; load = l; alarm_ack = a;
        @(negedge clk);
        tick_1hz = 1'b0; beat_pulse = 1'b0; load = 1'b0; alarm_ack = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = v;
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] digits();
        return 32'({min_tens, min_ones, sec_tens, sec_ones});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_digits", digits(), 32'h0000);
        check("reset_done", 32'(timer_done), 32'd1);
        check("reset_alarm", 32'(alarm), 32'd0);
        reset = 1'b0;

        // 01:00 countdown to expiry
        do_load(16'h0100);
        check("load_0100", digits(), 32'h0100);
        check("done_low", 32'(timer_done), 32'd0);
        dp_count = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("tick1_0059", digits(), 32'h0059);
        repeat (59) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("tick60_0000", digits(), 32'h0000);
        check("expired_done", 32'(timer_done), 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_at_zero", digits(), 32'h0000);
        check("one_done_pulse", 32'(dp_count), 32'd1);

        // Borrow chains
        do_load(16'h1000);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("borrow_0959", digits(), 32'h0959);
        do_load(16'h0010);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("borrow_0009", digits(), 32'h0009);

        // Clamping
        do_load(16'hCF7A);
        check("clamp_9959", digits(), 32'h9959);

        // Load beats tick; zero load gives no done_pulse
        do_load(16'h0005);
        {load_min_tens, load_min_ones, load_sec_tens, load_sec_ones} = 16'h0230;
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        check("load_over_tick", digits(), 32'h0230);
        enable = 1'b0;
        repeat (5) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("enable_low_frozen", digits(), 32'h0230);
        enable = 1'b1;
        dp_count = 0;
        do_load(16'h0000);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        check("zero_load_no_pulse", 32'(dp_count), 32'd0);

        // Full alarm sequence
        do_load(16'h0002);
        rises = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (8) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("beep_count", 32'(rises), 32'(BEEPS * ALARM_ON));
        check("alarm_idle_after", 32'(alarm), 32'd0);

        // Ack during second beep
        do_load(16'h0001);
        rises = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("alarm_first_beep", 32'(alarm), 32'(ALARM_ON));
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("second_beep", 32'(rises), 32'(2 * ALARM_ON));
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_silences", 32'(alarm), 32'd0);
        repeat (4) pulse(1'b0, 1'b1, 1'b0, 1'b0);
        check("no_third_beep", 32'(rises), 32'(2 * ALARM_ON));

        // Ack coincident with done_pulse wins
        do_load(16'h0001);
        rises = 0;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        alarm_ack = 1'b1;
        @(negedge clk);
        alarm_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("ack_beats_done", 32'(rises), 32'd0);

        // Async reset mid-count
        do_load(16'h0040);
        repeat (3) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        check("count_0037", digits(), 32'h0037);
        #2 reset = 1'b1;
        #1;
        check("async_rst_digits", digits(), 32'h0000);
        check("async_rst_done", 32'(timer_done), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Async reset mid-alarm
        do_load(16'h0001);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("alarm_before_rst", 32'(alarm), 32'(ALARM_ON));
        #2 reset = 1'b1;
        #1;
        check("async_rst_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
